// File: rtl/avalon_burst_master.sv
// avalon_burst_master
//
// Upstream command master for the Avalon-MM slave port. It turns user command, write-beat and
// read-beat handshakes into single or burst Avalon transfers. Only one command is in flight at
// a time. Read commands are aborted with a one-cycle err_timeout pulse when the slave stays
// silent for RD_TIMEOUT consecutive cycles.
//
// Ports
//   avl_clk, avl_rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready             command handshake: cmd_write, cmd_addr, cmd_len
//                               (cmd_len 0 = single transfer, N = burst of N beats)
//   wr_valid/ready, wr_data     write-beat handshake (wr_ready is combinational)
//   rd_valid, rd_data, rd_last  returned read beats, no backpressure
//   done, err_timeout           one-cycle completion / read-abort pulses
//   avl_*                       Avalon-MM master signals (all outputs registered)

module avalon_burst_master #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BURST_W    = 10,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic               avl_clk,
  input  logic               avl_rst_n,
  // command side
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [BURST_W-1:0] cmd_len,
  // write data side
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATA_W-1:0]  wr_data,
  // read data side
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_last,
  // status
  output logic               done,
  output logic               err_timeout,
  // Avalon-MM master
  output logic [ADDR_W-1:0]  avl_address,
  output logic               avl_read,
  output logic               avl_write,
  output logic [DATA_W-1:0]  avl_writedata,
  output logic [BURST_W-1:0] avl_burstcount,
  output logic               avl_beginbursttransfer,
  input  logic [DATA_W-1:0]  avl_readdata,
  input  logic               avl_readdatavalid
);

  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRdReq,
    StRdWait
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] beats_q;     // beats still to transfer
  logic               first_q;     // next write beat is the first of the command
  logic [CntW-1:0]    idle_cnt_q;  // consecutive silent cycles in StRdWait

  // done/err_timeout are high in the first idle cycle; holding cmd_ready low there makes
  // cmd_ready rise the cycle after completion. Gating with the reset keeps it 0 during reset.
  logic idle_free;
  assign idle_free = (state_q == StIdle) && !done && !err_timeout;
  assign cmd_ready = avl_rst_n && idle_free;
  assign wr_ready  = (state_q == StWr);

  always_ff @(posedge avl_clk or negedge avl_rst_n) begin
    if (!avl_rst_n) begin
      state_q                <= StIdle;
      addr_q                 <= '0;
      len_q                  <= '0;
      beats_q                <= '0;
      first_q                <= 1'b0;
      idle_cnt_q             <= '0;
      rd_valid               <= 1'b0;
      rd_data                <= '0;
      rd_last                <= 1'b0;
      done                   <= 1'b0;
      err_timeout            <= 1'b0;
      avl_address            <= '0;
      avl_read               <= 1'b0;
      avl_write              <= 1'b0;
      avl_writedata          <= '0;
      avl_burstcount         <= '0;
      avl_beginbursttransfer <= 1'b0;
    end else begin
      // Strobes default low; address, data and burstcount hold their last value.
      avl_read               <= 1'b0;
      avl_write              <= 1'b0;
      avl_beginbursttransfer <= 1'b0;
      rd_valid               <= 1'b0;
      rd_last                <= 1'b0;
      done                   <= 1'b0;
      err_timeout            <= 1'b0;

      case (state_q)
        StIdle: begin
          if (cmd_valid && idle_free) begin
            addr_q     <= cmd_addr;
            len_q      <= cmd_len;
            beats_q    <= (cmd_len == '0) ? BURST_W'(1) : cmd_len;
            first_q    <= 1'b1;
            idle_cnt_q <= '0;
            if (cmd_write) begin
              state_q <= StWr;
            end else begin
              // Read request is registered here so avl_read is high during StRdReq.
              state_q                <= StRdReq;
              avl_read               <= 1'b1;
              avl_address            <= cmd_addr;
              avl_burstcount         <= cmd_len;
              avl_beginbursttransfer <= (cmd_len != '0);
            end
          end
        end

        StWr: begin
          if (wr_valid) begin
            avl_write              <= 1'b1;
            avl_writedata          <= wr_data;
            avl_address            <= addr_q;
            avl_burstcount         <= len_q;
            avl_beginbursttransfer <= first_q && (len_q != '0);
            first_q                <= 1'b0;
            beats_q                <= beats_q - BURST_W'(1);
            if (beats_q == BURST_W'(1)) begin
              state_q <= StIdle;
              done    <= 1'b1;
            end
          end
        end

        StRdReq: begin
          state_q <= StRdWait;
        end

        StRdWait: begin
          if (avl_readdatavalid) begin
            rd_valid   <= 1'b1;
            rd_data    <= avl_readdata;
            idle_cnt_q <= '0;
            beats_q    <= beats_q - BURST_W'(1);
            if (beats_q == BURST_W'(1)) begin
              rd_last <= 1'b1;
              done    <= 1'b1;
              state_q <= StIdle;
            end
          end else if (idle_cnt_q == CntW'(RD_TIMEOUT - 1)) begin
            // This silent cycle is the RD_TIMEOUT-th in a row.
            err_timeout <= 1'b1;
            idle_cnt_q  <= '0;
            state_q     <= StIdle;
          end else begin
            idle_cnt_q <= idle_cnt_q + CntW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Directed bench for avalon_burst_master: a cycle table for single write, single read, stray
// read beat and a burst write with a bubble, followed by hand-written burst-read, timeout and
// mid-burst reset sequences.

module tb_avalon_burst_master;

  localparam int unsigned RdTimeout = 64;

  logic       avl_clk;
  logic       avl_rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [9:0] cmd_addr;
  logic [9:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       done;
  logic       err_timeout;
  logic [9:0] avl_address;
  logic       avl_read;
  logic       avl_write;
  logic [7:0] avl_writedata;
  logic [9:0] avl_burstcount;
  logic       avl_beginbursttransfer;
  logic [7:0] avl_readdata;
  logic       avl_readdatavalid;

  avalon_burst_master #(
    .ADDR_W    (10),
    .DATA_W    (8),
    .BURST_W   (10),
    .RD_TIMEOUT(RdTimeout)
  ) dut (
    .avl_clk               (avl_clk),
    .avl_rst_n             (avl_rst_n),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_write             (cmd_write),
    .cmd_addr              (cmd_addr),
    .cmd_len               (cmd_len),
    .wr_valid              (wr_valid),
    .wr_ready              (wr_ready),
    .wr_data               (wr_data),
    .rd_valid              (rd_valid),
    .rd_data               (rd_data),
    .rd_last               (rd_last),
    .done                  (done),
    .err_timeout           (err_timeout),
    .avl_address           (avl_address),
    .avl_read              (avl_read),
    .avl_write             (avl_write),
    .avl_writedata         (avl_writedata),
    .avl_burstcount        (avl_burstcount),
    .avl_beginbursttransfer(avl_beginbursttransfer),
    .avl_readdata          (avl_readdata),
    .avl_readdatavalid     (avl_readdatavalid)
  );

  initial avl_clk = 1'b0;
  always #5 avl_clk = ~avl_clk;

  int errors = 0;
  int checks = 0;

  // Flags order: cmd_ready wr_ready avl_write avl_read beginburst rd_valid rd_last done err
  typedef struct {
    logic       cv;
    logic       cw;
    logic [9:0] ca;
    logic [9:0] cl;
    logic       wv;
    logic [7:0] wd;
    logic       rv;
    logic [7:0] rd;
    logic [8:0] ef;
    logic [9:0] ea;
    logic [9:0] eb;
    logic [7:0] ewd;
    logic [7:0] erd;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [44:0] outs();
    return {cmd_ready, wr_ready, avl_write, avl_read, avl_beginbursttransfer, rd_valid, rd_last,
            done, err_timeout, avl_address, avl_burstcount, avl_writedata, rd_data};
  endfunction

  task automatic clear_inputs();
    cmd_valid         = 1'b0;
    cmd_write         = 1'b0;
    cmd_addr          = '0;
    cmd_len           = '0;
    wr_valid          = 1'b0;
    wr_data           = '0;
    avl_readdata      = '0;
    avl_readdatavalid = 1'b0;
  endtask

  logic [8:0] pat;
  int         n;
  logic       exp_v;
  logic       exp_last;
  logic [7:0] exp_data;

  initial begin
    //            cv    cw    ca      cl     wv    wd     rv    rd     flags         addr    burst  wdata  rdata
    vecs[0]  = '{1'b1, 1'b1, 10'd3, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 9'b100000000, 10'd0, 10'd0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 8'h07, 1'b0, 8'h00, 9'b010000000, 10'd0, 10'd0, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 9'b001000010, 10'd3, 10'd0, 8'h07, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 10'd1, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 9'b100000000, 10'd3, 10'd0, 8'h07, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 9'b000100000, 10'd1, 10'd0, 8'h07, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 8'h07, 9'b000000000, 10'd1, 10'd0, 8'h07, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 9'b000001110, 10'd1, 10'd0, 8'h07, 8'h07};
    vecs[7]  = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 8'hAA, 9'b100000000, 10'd1, 10'd0, 8'h07, 8'h07};
    vecs[8]  = '{1'b1, 1'b1, 10'd0, 10'd4, 1'b0, 8'h00, 1'b0, 8'h00, 9'b100000000, 10'd1, 10'd0, 8'h07, 8'h07};
    vecs[9]  = '{1'b1, 1'b0, 10'h155, 10'd1, 1'b1, 8'h01, 1'b0, 8'h00, 9'b010000000, 10'd1, 10'd0, 8'h07, 8'h07};
    vecs[10] = '{1'b1, 1'b0, 10'h155, 10'd1, 1'b1, 8'h02, 1'b0, 8'h00, 9'b011010000, 10'd0, 10'd4, 8'h01, 8'h07};
    vecs[11] = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 9'b011000000, 10'd0, 10'd4, 8'h02, 8'h07};
    vecs[12] = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 8'h03, 1'b0, 8'h00, 9'b010000000, 10'd0, 10'd4, 8'h02, 8'h07};
    vecs[13] = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 8'h04, 1'b0, 8'h00, 9'b011000000, 10'd0, 10'd4, 8'h03, 8'h07};
    vecs[14] = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 9'b001000010, 10'd0, 10'd4, 8'h04, 8'h07};
    vecs[15] = '{1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00, 1'b0, 8'h00, 9'b100000000, 10'd0, 10'd4, 8'h04, 8'h07};

    clear_inputs();
    avl_rst_n = 1'b0;
    repeat (2) @(negedge avl_clk);
    #1 check("reset_outputs", 64'(outs()), 64'd0);
    @(negedge avl_clk);
    avl_rst_n = 1'b1;
    #1 check("post_reset_idle", 64'(outs()), 64'({9'b100000000, 36'd0}));

    // Cycle table: single write, single read, stray beat, busy command, burst write with bubble
    for (int i = 0; i < 16; i++) begin
      @(negedge avl_clk);
      cmd_valid         = vecs[i].cv;
      cmd_write         = vecs[i].cw;
      cmd_addr          = vecs[i].ca;
      cmd_len           = vecs[i].cl;
      wr_valid          = vecs[i].wv;
      wr_data           = vecs[i].wd;
      avl_readdatavalid = vecs[i].rv;
      avl_readdata      = vecs[i].rd;
      #1 check($sformatf("vec%0d", i), 64'(outs()),
               64'({vecs[i].ef, vecs[i].ea, vecs[i].eb, vecs[i].ewd, vecs[i].erd}));
    end

    // Burst read of 4 with non-contiguous beats and a stray fifth beat
    @(negedge avl_clk);
    clear_inputs();
    cmd_valid = 1'b1;
    cmd_addr  = 10'h020;
    cmd_len   = 10'd4;
    #1 check("brd_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge avl_clk);
    cmd_valid = 1'b0;
    #1 check("brd_request", 64'({avl_read, avl_beginbursttransfer, avl_address, avl_burstcount}),
             64'({1'b1, 1'b1, 10'h020, 10'd4}));
    pat      = 9'b011001101;
    n        = 0;
    exp_v    = 1'b0;
    exp_last = 1'b0;
    exp_data = 8'h00;
    for (int i = 0; i < 9; i++) begin
      @(negedge avl_clk);
      avl_readdatavalid = pat[i];
      avl_readdata      = 8'h10 + 8'(i);
      #1 check($sformatf("brd_beat%0d", i),
               64'({rd_valid, rd_last, done, err_timeout, rd_valid ? rd_data : 8'h00}),
               64'({exp_v, exp_last, exp_last, 1'b0, exp_v ? exp_data : 8'h00}));
      if (pat[i] && n < 4) begin
        n++;
        exp_v    = 1'b1;
        exp_last = (n == 4);
        exp_data = 8'h10 + 8'(i);
      end else begin
        exp_v    = 1'b0;
        exp_last = 1'b0;
      end
    end
    check("brd_idle_after", 64'(cmd_ready), 64'd1);

    // Timeout: read of 2, one beat returned, then silence
    @(negedge avl_clk);
    clear_inputs();
    cmd_valid = 1'b1;
    cmd_addr  = 10'd5;
    cmd_len   = 10'd2;
    @(negedge avl_clk);
    cmd_valid = 1'b0;
    for (int i = 0; i <= int'(RdTimeout) + 2; i++) begin
      @(negedge avl_clk);
      avl_readdatavalid = (i == 0);
      avl_readdata      = 8'h3C;
      #1 check($sformatf("tmo_cycle%0d", i), 64'({rd_valid, err_timeout, done, cmd_ready}),
               64'({1'(i == 1), 1'(i == int'(RdTimeout) + 1), 1'b0,
                    1'(i >= int'(RdTimeout) + 2)}));
    end

    // Reset in the middle of a 4-beat write burst, then a clean single write
    @(negedge avl_clk);
    clear_inputs();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 10'h0C0;
    cmd_len   = 10'd4;
    @(negedge avl_clk);
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 8'h11;
    @(negedge avl_clk);
    wr_data = 8'h22;
    @(negedge avl_clk);
    wr_valid = 1'b0;
    #1 check("rst_beat2_on_bus", 64'({avl_write, avl_writedata, done}), 64'({1'b1, 8'h22, 1'b0}));
    #2 avl_rst_n = 1'b0;
    #1 check("rst_async_clear", 64'(outs()), 64'd0);
    @(negedge avl_clk);
    #1 check("rst_held_clear", 64'(outs()), 64'd0);
    @(negedge avl_clk);
    avl_rst_n = 1'b1;
    #1 check("rst_release_idle", 64'(outs()), 64'({9'b100000000, 36'd0}));
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 10'd9;
    cmd_len   = 10'd0;
    @(negedge avl_clk);
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 8'h5A;
    #1 check("rst_new_wr_ready", 64'({wr_ready, cmd_ready}), 64'({1'b1, 1'b0}));
    @(negedge avl_clk);
    wr_valid = 1'b0;
    #1 check("rst_new_write", 64'({avl_write, done, avl_beginbursttransfer, avl_address,
                                   avl_writedata, avl_burstcount}),
             64'({1'b1, 1'b1, 1'b0, 10'd9, 8'h5A, 10'd0}));
    @(negedge avl_clk);
    #1 check("rst_new_idle", 64'({cmd_ready, avl_write, done}), 64'({1'b1, 1'b0, 1'b0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
